lcd_sequencer: RTL and testbench
================================

# lcd_sequencer

Dot/line timing sequencer for the LCD pipeline. Counts dots (456 per line) and lines (154 per frame), and decodes the current LCD mode and `LY`. Generates the VBlank and STAT interrupt pulses and the CPU access grants for VRAM and OAM. It sits between the LCD control registers and the display driver, and replaces ad-hoc mode derivation from HDMI raster position with true Game Boy timing.

## Interface
Parameters:
- `DOTS_PER_LINE`, 456: dots per line, including HBlank.
- `LINES_PER_FRAME`, 154: lines per frame, including VBlank.
- `OAM_DOTS`, 80: length of mode 2.
- `XFER_DOTS`, 172: length of mode 3 (fixed).
- `VISIBLE_LINES`, 144: first VBlank line index.

Ports:
- `clk_cpu` in 1: the single clock.
- `rst` in 1: synchronous, active-high reset.
- `dot_en` in 1: one-cycle dot strobe; counters advance only when it is high.
- `lcd_enable` in 1: `LCDC[7]`.
- `lyc` in 8: LY compare register.
- `stat_sel` in 4: STAT interrupt source enables; [0] HBlank, [1] VBlank, [2] OAM, [3] LYC.
- `mode` out 2: 00 HBlank, 01 VBlank, 10 OAM search, 11 transfer.
- `ly` out 8: current line.
- `dot` out 9: current dot within the line.
- `coincidence` out 1: `ly == lyc`.
- `irq_vblank` out 1: one-cycle pulse.
- `irq_stat` out 1: one-cycle pulse.
- `line_start` out 1: one-cycle pulse at dot 0 of every line 0..143.
- `cpu_vram_ok` out 1: CPU may access VRAM.
- `cpu_oam_ok` out 1: CPU may access OAM.

## Operation
- State registers: `dot_q` (9b), `ly_q` (8b), `stat_prev` (1b), and the registered pulse outputs.
- Counting: on `dot_en`, `dot_q` increments.
  - At `DOTS_PER_LINE-1`, `dot_q` wraps to 0 and `ly_q` increments.
  - When `ly_q` reaches `LINES_PER_FRAME-1` and the line wraps, `ly_q` goes to 0.
  - When `dot_en` is low, all counters hold.
- Mode decode (combinational from the counters, priority order):
  - `ly_q >= 144` → 01.
  - else `dot_q < 80` → 10.
  - else `dot_q < 252` → 11.
  - else → 00.
- `coincidence` is combinational `ly_q == lyc`. It is re-evaluated every clock, including when `lyc` changes while `dot_en` is low.
- STAT line: `stat_line = (sel[0]&mode==00) | (sel[1]&mode==01) | (sel[2]&mode==10) | (sel[3]&coincidence)`.
  - `irq_stat` is asserted for one cycle on the clock after `stat_line` rises (0→1 against `stat_prev`).
  - There is no retrigger while the line stays high. This is STAT blocking: an HBlank→OAM transition with both sources enabled gives no second pulse.
- `irq_vblank`: registered pulse, one cycle, on the clock after `ly_q` becomes 144.
- `line_start`: registered pulse, one cycle, on the clock after `dot_q` becomes 0 with `ly_q < 144`.
- Access grants:
  - `cpu_vram_ok = (mode != 11)`.
  - `cpu_oam_ok = (mode == 00 || mode == 01)`.
- LCD disabled (`lcd_enable` = 0):
  - Next clock clears `dot_q` and `ly_q`, and forces `stat_prev` to 0.
  - `mode` reads 00; both grants read 1.
  - All pulses are 0 and held low while disabled. Disabling mid-frame creates no interrupt.
- Re-enable: counting starts at `ly=0`, `dot=0`, `mode=10`. If `sel[2]` or (`sel[3]` with `lyc=0`) is set, `irq_stat` fires on the second enabled clock.

## Timing
- Reset values:
  - `dot=0`, `ly=0`.
  - `irq_vblank=0`, `irq_stat=0`, `line_start=0`, `stat_prev=0`.
  - `mode` is 10 if `lcd_enable` else 00.
  - `coincidence = (lyc == 0)`.
  - Grants follow `mode`.
- `rst` overrides `lcd_enable` and `dot_en`.
- `mode`, `ly`, `dot`, `coincidence`, and the grants have zero latency from the counters.
- Interrupt and `line_start` pulses lag the causing counter edge by one `clk_cpu`. A pulse is never longer than one cycle, regardless of `dot_en` rate.
- Line wrap and frame wrap occur on the same `dot_en` edge; `ly` 153→0 together with `dot` 455→0.
- `lyc` write coinciding with a counter step: compare uses the post-step `ly_q` and the new `lyc`.
- Frame period: 70224 `dot_en` strobes.

## Structure
- `constants.sv` gains:
  - `lcd_mode_t`, a 2-bit enum: `MODE_HBLANK`, `MODE_VBLANK`, `MODE_OAM`, `MODE_XFER`.
  - Timing constants `DOTS_PER_LINE`, `LINES_PER_FRAME`, `OAM_DOTS`, `XFER_DOTS`, `VISIBLE_LINES`.
- One sub-module, `edge_pulse`: a rising-edge detector with a synchronous clear, instanced for `irq_stat`, `irq_vblank`, and `line_start`.
- The display driver consumes `mode` and `ly` in place of its raster-derived values.

## Test plan
- Reset, `lcd_enable=1`, `dot_en` constant 1 → `mode` 10 for dots 0–79, 11 for 80–251, 00 for 252–455. `ly` steps to 1 after 456 clocks.
- Run to `ly=144` → `irq_vblank` is high for exactly one cycle, at clock 65664+1. `mode` is 01 with both grants 1. `ly` wraps to 0 after 70224 clocks.
- `stat_sel=4'b0101` (HBlank+OAM) → one `irq_stat` per line, at dot 252+1 only. No pulse at the HBlank→OAM boundary, and no pulse at line 144.
- `stat_sel=4'b1000`, `lyc=10` → `coincidence` is high for all of line 10 and `irq_stat` fires once. Writing `lyc=10` while `ly=10` from a prior `lyc=3` also pulses once.
- `dot_en` at 1 in 4 → the same sequence at 4× the clocks, and every pulse stays a single cycle.
- Deassert `lcd_enable` at `ly=50` with `sel=4'b1111` → no pulses, `mode` 00, counters 0. Reasserting gives `mode` 10 and `irq_stat` on the second clock.

Source files
------------

// File: rtl/lcd_sequencer_pkg.sv
// Shared LCD timing types and constants: mode encoding, Game Boy line/frame geometry
// and the mode decode used by the sequencer.
package lcd_sequencer_pkg;

    typedef enum logic [1:0] {
        MODE_HBLANK = 2'b00,
        MODE_VBLANK = 2'b01,
        MODE_OAM    = 2'b10,
        MODE_XFER   = 2'b11
    } lcd_mode_t;

    localparam int unsigned DOTS_PER_LINE   = 456;
    localparam int unsigned LINES_PER_FRAME = 154;
    localparam int unsigned OAM_DOTS        = 80;
    localparam int unsigned XFER_DOTS       = 172;
    localparam int unsigned VISIBLE_LINES   = 144;

    // VBlank lines win over the dot position; within a visible line the dot picks the mode.
    function automatic lcd_mode_t decode_mode(
        input logic [8:0]  dot,
        input logic [7:0]  ly,
        input int unsigned oam_dots,
        input int unsigned xfer_end,
        input int unsigned visible_lines
    );
        lcd_mode_t m;
        if (32'(ly) >= visible_lines) begin
            m = MODE_VBLANK;
        end else if (32'(dot) < oam_dots) begin
            m = MODE_OAM;
        end else if (32'(dot) < xfer_end) begin
            m = MODE_XFER;
        end else begin
            m = MODE_HBLANK;
        end
        return m;
    endfunction

endpackage

// File: rtl/lcd_sequencer_if.sv
// Signal bundle between the LCD control registers / display driver and the sequencer.
interface lcd_sequencer_if;
    import lcd_sequencer_pkg::*;

    logic       dot_en;
    logic       lcd_enable;
    logic [7:0] lyc;
    logic [3:0] stat_sel;
    lcd_mode_t  mode;
    logic [7:0] ly;
    logic [8:0] dot;
    logic       coincidence;
    logic       irq_vblank;
    logic       irq_stat;
    logic       line_start;
    logic       cpu_vram_ok;
    logic       cpu_oam_ok;

    modport master (
        output dot_en, lcd_enable, lyc, stat_sel,
        input  mode, ly, dot, coincidence, irq_vblank, irq_stat, line_start,
               cpu_vram_ok, cpu_oam_ok
    );

    modport slave (
        input  dot_en, lcd_enable, lyc, stat_sel,
        output mode, ly, dot, coincidence, irq_vblank, irq_stat, line_start,
               cpu_vram_ok, cpu_oam_ok
    );

endinterface

// File: rtl/lcd_sequencer_edge_pulse.sv
// Rising-edge detector: one-cycle registered pulse when the level goes 0->1.
// A synchronous clear drops both the pulse and the remembered level.
module edge_pulse (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_level,
    output logic o_pulse
);

    logic r_prev;
    logic r_pulse;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_prev  <= i_level;
            r_pulse <= i_level & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/lcd_sequencer.sv
// Dot/line timing sequencer: counts dots and lines, decodes LCD mode and LY, and
// raises VBlank/STAT interrupts, line-start strobes and CPU VRAM/OAM access grants.
module lcd_sequencer #(
    parameter int unsigned DOTS_PER_LINE   = lcd_sequencer_pkg::DOTS_PER_LINE,
    parameter int unsigned LINES_PER_FRAME = lcd_sequencer_pkg::LINES_PER_FRAME,
    parameter int unsigned OAM_DOTS        = lcd_sequencer_pkg::OAM_DOTS,
    parameter int unsigned XFER_DOTS       = lcd_sequencer_pkg::XFER_DOTS,
    parameter int unsigned VISIBLE_LINES   = lcd_sequencer_pkg::VISIBLE_LINES
) (
    input  logic           clk_cpu,
    input  logic           rst,
    lcd_sequencer_if.slave lcd_bus
);
    import lcd_sequencer_pkg::*;

    logic [8:0] r_dot_q;
    logic [7:0] r_ly_q;

    logic       w_dot_last;
    logic       w_ly_last;
    logic       w_clr;
    lcd_mode_t  w_mode;
    logic       w_coincidence;
    logic       w_stat_line;
    logic       w_vblank_level;
    logic       w_line_start_level;
    logic       w_irq_stat;
    logic       w_irq_vblank;
    logic       w_line_start;

    assign w_dot_last = (r_dot_q == 9'(DOTS_PER_LINE - 1));
    assign w_ly_last  = (r_ly_q == 8'(LINES_PER_FRAME - 1));
    assign w_clr      = ~lcd_bus.lcd_enable;

    // A disabled LCD parks both counters at the top of frame 0.
    always_ff @(posedge clk_cpu) begin
        if (rst || !lcd_bus.lcd_enable) begin
            r_dot_q <= 9'd0;
            r_ly_q  <= 8'd0;
        end else if (lcd_bus.dot_en) begin
            if (w_dot_last) begin
                r_dot_q <= 9'd0;
                r_ly_q  <= w_ly_last ? 8'd0 : r_ly_q + 8'd1;
            end else begin
                r_dot_q <= r_dot_q + 9'd1;
            end
        end
    end

    always_comb begin
        w_mode = MODE_HBLANK;
        if (lcd_bus.lcd_enable) begin
            w_mode = decode_mode(r_dot_q, r_ly_q, OAM_DOTS, OAM_DOTS + XFER_DOTS,
                                 VISIBLE_LINES);
        end
    end

    assign w_coincidence = (r_ly_q == lcd_bus.lyc);

    // Sources are OR-ed into one line, so a hand-over between enabled sources
    // keeps the line high and produces no second interrupt.
    assign w_stat_line = (lcd_bus.stat_sel[0] & (w_mode == MODE_HBLANK))
                       | (lcd_bus.stat_sel[1] & (w_mode == MODE_VBLANK))
                       | (lcd_bus.stat_sel[2] & (w_mode == MODE_OAM))
                       | (lcd_bus.stat_sel[3] & w_coincidence);

    assign w_vblank_level     = (r_ly_q == 8'(VISIBLE_LINES));
    assign w_line_start_level = (r_dot_q == 9'd0) && (r_ly_q < 8'(VISIBLE_LINES));

    edge_pulse u_stat_pulse (
        .i_clk   (clk_cpu),
        .i_rst   (rst),
        .i_clr   (w_clr),
        .i_level (w_stat_line),
        .o_pulse (w_irq_stat)
    );

    edge_pulse u_vblank_pulse (
        .i_clk   (clk_cpu),
        .i_rst   (rst),
        .i_clr   (w_clr),
        .i_level (w_vblank_level),
        .o_pulse (w_irq_vblank)
    );

    edge_pulse u_line_start_pulse (
        .i_clk   (clk_cpu),
        .i_rst   (rst),
        .i_clr   (w_clr),
        .i_level (w_line_start_level),
        .o_pulse (w_line_start)
    );

    assign lcd_bus.mode        = w_mode;
    assign lcd_bus.ly          = r_ly_q;
    assign lcd_bus.dot         = r_dot_q;
    assign lcd_bus.coincidence = w_coincidence;
    assign lcd_bus.irq_stat    = w_irq_stat;
    assign lcd_bus.irq_vblank  = w_irq_vblank;
    assign lcd_bus.line_start  = w_line_start;
    assign lcd_bus.cpu_vram_ok = (w_mode != MODE_XFER);
    assign lcd_bus.cpu_oam_ok  = (w_mode == MODE_HBLANK) || (w_mode == MODE_VBLANK);

endmodule

// File: tb/tb_lcd_sequencer.sv
// Bench for lcd_sequencer: frame-position reference model (one strobe counter per frame)
// compared against every DUT output after each clock.
module tb_lcd_sequencer;

    localparam int DPL   = 456;
    localparam int LPF   = 154;
    localparam int FRAME = DPL * LPF;

    logic clk = 1'b0;
    logic rst;

    lcd_sequencer_if bus ();

    lcd_sequencer dut (
        .clk_cpu (clk),
        .rst     (rst),
        .lcd_bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: strobes into the current frame plus remembered interrupt levels.
    int m_n = 0;
    bit m_prev_stat = 0, m_prev_vb = 0, m_prev_ls = 0;
    bit e_stat = 0, e_vb = 0, e_ls = 0;

    int en_clk = 0;
    int vb_seen = 0, vb_at = 0, stat_seen = 0, ls_seen = 0;

    function automatic int f_dot();
        return m_n % DPL;
    endfunction

    function automatic int f_ly();
        return m_n / DPL;
    endfunction

    function automatic int f_mode();
        if (!bus.lcd_enable) return 0;
        if (f_ly() >= 144) return 1;
        if (f_dot() < 80) return 2;
        if (f_dot() < 80 + 172) return 3;
        return 0;
    endfunction

    function automatic bit f_stat_line();
        bit coin;
        coin = (f_ly() == int'(bus.lyc));
        return (bus.stat_sel[0] && f_mode() == 0) || (bus.stat_sel[1] && f_mode() == 1) ||
               (bus.stat_sel[2] && f_mode() == 2) || (bus.stat_sel[3] && coin);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("dot", 16'(bus.dot), 16'(f_dot()));
        chk("ly", 16'(bus.ly), 16'(f_ly()));
        chk("mode", 16'(bus.mode), 16'(f_mode()));
        chk("coincidence", 16'(bus.coincidence), 16'(f_ly() == int'(bus.lyc)));
        chk("cpu_vram_ok", 16'(bus.cpu_vram_ok), 16'(f_mode() != 3));
        chk("cpu_oam_ok", 16'(bus.cpu_oam_ok), 16'(f_mode() == 0 || f_mode() == 1));
        chk("irq_vblank", 16'(bus.irq_vblank), 16'(e_vb));
        chk("irq_stat", 16'(bus.irq_stat), 16'(e_stat));
        chk("line_start", 16'(bus.line_start), 16'(e_ls));
    endtask

    task automatic tick();
        bit s, v, l;
        s = f_stat_line();
        v = (f_ly() == 144);
        l = (f_dot() == 0) && (f_ly() < 144);
        @(posedge clk);
        if (rst || !bus.lcd_enable) begin
            m_n = 0;
            e_stat = 0; e_vb = 0; e_ls = 0;
            m_prev_stat = 0; m_prev_vb = 0; m_prev_ls = 0;
        end else begin
            e_stat = s && !m_prev_stat;
            e_vb   = v && !m_prev_vb;
            e_ls   = l && !m_prev_ls;
            m_prev_stat = s; m_prev_vb = v; m_prev_ls = l;
            if (bus.dot_en) m_n = (m_n + 1) % FRAME;
        end
        en_clk++;
        #1;
        if (bus.irq_vblank) begin
            vb_seen++;
            vb_at = en_clk;
        end
        if (bus.irq_stat && en_clk >= 3) stat_seen++;
        if (bus.line_start && en_clk >= 2) ls_seen++;
        check_all();
    endtask

    task automatic run_to(input int target, input int budget);
        int b;
        b = budget;
        while (m_n != target && b > 0) begin
            tick();
            b--;
        end
        chk("reach_ly", 16'(bus.ly), 16'(target / DPL));
        chk("reach_dot", 16'(bus.dot), 16'(target % DPL));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.lcd_enable = 1'b0;
        bus.dot_en = 1'b1;
        bus.lyc = 8'd10;
        bus.stat_sel = 4'b1000;

        // Reset while disabled, then while enabled; rst overrides lcd_enable and dot_en.
        tick();
        chk("rst_dis_mode", 16'(bus.mode), 16'd0);
        bus.lcd_enable = 1'b1;
        tick();
        tick();
        chk("rst_en_mode", 16'(bus.mode), 16'd2);
        chk("rst_irq_stat", 16'(bus.irq_stat), 16'd0);
        rst = 1'b0;

        // Full-rate run: one line takes 456 strobes.
        run_to(DPL, 1000);
        chk("ly_after_456", 16'(bus.ly), 16'd1);

        // LY compare on line 10, then an LYC rewrite with dot_en held low.
        run_to(10 * DPL + 100, 6000);
        chk("coin_line10", 16'(bus.coincidence), 16'd1);
        bus.dot_en = 1'b0;
        tick();
        bus.lyc = 8'd3;
        #1;
        check_all();
        chk("coin_lyc3", 16'(bus.coincidence), 16'd0);
        tick();
        bus.lyc = 8'd10;
        #1;
        check_all();
        tick();
        chk("lyc_rewrite_pulse", 16'(bus.irq_stat), 16'd1);
        tick();
        chk("lyc_rewrite_single", 16'(bus.irq_stat), 16'd0);
        bus.dot_en = 1'b1;
        run_to(12 * DPL, 2000);

        // Quarter-rate strobes with random STAT sources and LYC values.
        for (int i = 0; i < 4 * DPL; i++) begin
            bus.dot_en = (i % 4 == 3);
            if (i % 64 == 0) begin
                bus.stat_sel = 4'($urandom);
                bus.lyc = 8'($urandom_range(11, 14));
            end
            tick();
        end
        chk("quarter_ly", 16'(bus.ly), 16'd13);

        // Mid-frame disable with every STAT source enabled.
        bus.stat_sel = 4'b1111;
        bus.lcd_enable = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bus.dot_en = 1'($urandom);
            bus.lyc = 8'($urandom_range(0, 2));
            tick();
        end
        chk("dis_mode", 16'(bus.mode), 16'd0);
        chk("dis_ly", 16'(bus.ly), 16'd0);
        chk("dis_dot", 16'(bus.dot), 16'd0);
        chk("dis_vram_ok", 16'(bus.cpu_vram_ok), 16'd1);
        chk("dis_oam_ok", 16'(bus.cpu_oam_ok), 16'd1);

        // Re-enable: OAM source set, so the first enabled edge registers irq_stat.
        bus.stat_sel = 4'b0101;
        bus.lyc = 8'd200;
        bus.dot_en = 1'b1;
        bus.lcd_enable = 1'b1;
        #1;
        chk("reen_mode", 16'(bus.mode), 16'd2);
        en_clk = 0;
        vb_seen = 0;
        stat_seen = 0;
        ls_seen = 0;
        tick();
        chk("reen_irq_stat", 16'(bus.irq_stat), 16'd1);
        tick();
        chk("reen_irq_stat_end", 16'(bus.irq_stat), 16'd0);

        // One full frame plus a margin at full rate, sel = HBlank + OAM.
        while (en_clk < FRAME + 60) begin
            tick();
            if (en_clk == 65664 + 1) chk("vblank_time", 16'(bus.irq_vblank), 16'd1);
            if (en_clk == 65664 + 1) chk("vblank_mode", 16'(bus.mode), 16'd1);
            if (en_clk == FRAME - 1) chk("pre_wrap_ly", 16'(bus.ly), 16'd153);
            if (en_clk == FRAME - 1) chk("pre_wrap_dot", 16'(bus.dot), 16'd455);
            if (en_clk == FRAME) chk("wrap_ly", 16'(bus.ly), 16'd0);
            if (en_clk == FRAME) chk("wrap_dot", 16'(bus.dot), 16'd0);
        end
        chk("vblank_count", 16'(vb_seen), 16'd1);
        chk("vblank_at", 16'(vb_at), 16'(65665));
        // 144 HBlank entries on lines 0..143, plus OAM of the next frame's line 0.
        chk("stat_count", 16'(stat_seen), 16'd145);
        // Lines 1..143, plus line 0 of the next frame.
        chk("line_start_count", 16'(ls_seen), 16'd144);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
